pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage of FETCH; sits directly upstream of the branch-target adder and consumes that adder's registered target.
- Holds the architectural PC and produces PC and PC+4 for instruction memory and the adder.
- Selects among sequential increment, jump target and branch target.
- Sequences the one-cycle wait a taken branch needs before the adder's registered target is valid; signals pipeline flush.

Parameters:
WIDTH, 32, PC/address width in bits
RESET_PC, 'h0000_0000, PC value loaded on reset (must be 4-byte aligned)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
stop  input  1  stall from hazard unit; same signal that gates the branch-target adder
branch_taken  input  1  from decode: branch resolved taken this cycle
bnq  input  WIDTH  branch target from the branch-target adder, registered
jump  input  1  from decode: unconditional jump this cycle
jump_target  input  WIDTH  jump destination address
pc  output  WIDTH  current fetch address
pc_plus4  output  WIDTH  pc + 4, registered alongside pc
fetch_valid  output  1  current pc is a real fetch
flush  output  1  squash the IF/ID instruction this cycle
addr_err  output  1  one-cycle pulse: loaded target was misaligned

Behaviour:
- Reset (rst=0, async) forces:
  - pc=RESET_PC, pc_plus4=RESET_PC+4.
  - state=PC_RUN, flush=0, addr_err=0, fetch_valid=0.
  - After release, fetch_valid rises at the first clock edge.
- All outputs are registered; none depends combinationally on any input.
- FSM states: PC_RUN, PC_BR_WAIT.
- PC_RUN, priority highest first, evaluated at each rising edge:
  1. jump=1: pc<=jump_target, flush<=1, fetch_valid<=1, stay PC_RUN. Honoured even when stop=1.
  2. branch_taken=1 and stop=0: pc held, flush<=1, fetch_valid<=0, go to PC_BR_WAIT. The adder captures the target on this same edge.
  3. stop=1: pc, pc_plus4 and fetch_valid held; flush<=0. A branch_taken asserted with stop=1 is ignored; decode must re-present it.
  4. Otherwise: pc<=pc+4, flush<=0, fetch_valid<=1.
- PC_BR_WAIT (always exactly one cycle):
  - pc<=bnq, flush<=0, fetch_valid<=1, return to PC_RUN.
  - Taken unconditionally: stop, jump and branch_taken are all ignored. The adder is already frozen with the correct bnq if stop rises here.
- Whenever pc is loaded, pc_plus4 is loaded with the new pc + 4.
- Alignment:
  - The value loaded into pc always has bits [1:0] cleared.
  - If a jump_target or bnq being loaded has nonzero [1:0], addr_err=1 for exactly the cycle after the load; otherwise addr_err=0.
- Arithmetic is modulo 2^WIDTH: pc='hFFFF_FFFC increments to 'h0000_0000, and pc_plus4 at pc='hFFFF_FFFC is 'h0000_0000. No overflow flag.
- Reset asserted mid-operation (including in PC_BR_WAIT) abandons the pending branch; pc returns to RESET_PC.
- flush is never high for two consecutive cycles from a single redirect.

Decomposition:
- Shared package fetch_pkg holds:
  - enum pc_state_t {PC_RUN, PC_BR_WAIT}
  - constant INSTR_BYTES=4
  - default RESET_PC
  - an align function clearing the low 2 bits
- No sub-module. The incrementer is a single expression; the FSM and PC register stay in one module (~150 lines).

Test Plan:
1. Reset/sequential: hold rst=0, release, idle inputs 4 cycles -> pc=0,4,8,12; pc_plus4=4,8,12,16; fetch_valid=0 then 1.
2. Stall: from pc=8, assert stop 3 cycles -> pc stays 8, fetch_valid stays 1, flush=0; after deassert, pc=12.
3. Taken branch: pc=0x10, pulse branch_taken with stop=0, drive bnq=0x40 on the following cycle -> next cycle pc=0x10, flush=1, fetch_valid=0; then pc=0x40, pc_plus4=0x44, flush=0.
4. Jump beats branch: jump=1, jump_target=0x200 with branch_taken=1 -> pc=0x200, flush=1 for one cycle, FSM stays PC_RUN. Repeat with stop=1 -> jump still taken.
5. Misaligned/wrap: jump_target=0x103 -> pc=0x100, addr_err=1 for one cycle. From pc='hFFFF_FFFC with no stop -> pc=0, no error.
6. Reset in PC_BR_WAIT: assert rst asynchronously mid-cycle after branch_taken -> pc=RESET_PC immediately, flush=0; bnq is not loaded after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the FETCH stage.
//   - pc_state_t       : program-counter sequencer FSM states
//   - INSTR_BYTES      : size of one instruction in bytes (PC step)
//   - DEFAULT_RESET_PC : default value loaded into the PC on reset
//   - align_addr()     : clears the low two bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [0:0] {
    PC_RUN     = 1'b0,
    PC_BR_WAIT = 1'b1
  } pc_state_t;

  localparam int INSTR_BYTES = 4;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Written at 64 bits so any PC width up to 64 can use it; callers
  // widen the operand and truncate the result back to their own width.
  function automatic logic [63:0] align_addr(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage : fetch_pkg

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Bundles the decode/hazard-side controls and the PC outputs of the
//   program-counter sequencer.
//
//   Handshake: there is no valid/ready pair on this bus. Control inputs
//   (stop, branch_taken, jump) are single-cycle level qualifiers sampled
//   at every rising clk edge; a branch_taken that arrives while stop=1 is
//   dropped and must be presented again by decode. fetch_valid marks the
//   cycles in which pc is a real fetch address.
//
//   Modports:
//     master : decode / hazard / adder side (drives controls, sees PC)
//     slave  : pc_sequencer (consumes controls, drives PC outputs)
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             stop;
  logic             branch_taken;
  logic [WIDTH-1:0] bnq;
  logic             jump;
  logic [WIDTH-1:0] jump_target;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             fetch_valid;
  logic             flush;
  logic             addr_err;

  modport master (
    output stop,
    output branch_taken,
    output bnq,
    output jump,
    output jump_target,
    input  pc,
    input  pc_plus4,
    input  fetch_valid,
    input  flush,
    input  addr_err
  );

  modport slave (
    input  stop,
    input  branch_taken,
    input  bnq,
    input  jump,
    input  jump_target,
    output pc,
    output pc_plus4,
    output fetch_valid,
    output flush,
    output addr_err
  );

endinterface : pc_sequencer_if

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter stage of FETCH. Holds the architectural PC, produces
//   PC and PC+4, and chooses between sequential increment, jump target and
//   branch target. A taken branch costs one wait cycle (PC_BR_WAIT) because
//   the branch-target adder registers its result on the same edge the
//   branch is accepted; the PC picks up that registered target (bnq) on the
//   following edge.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst   : asynchronous active-low reset
//     bus   : pc_sequencer_if.slave
//               in : stop, branch_taken, bnq, jump, jump_target
//               out: pc, pc_plus4, fetch_valid, flush, addr_err
//     state : current FSM state (debug visibility)
//
//   All outputs are registered.
// ---------------------------------------------------------------------------
module pc_sequencer
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.slave     bus,
  output pc_state_t         state
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

  pc_state_t        state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus4_q;
  logic             fetch_valid_q;
  logic             flush_q;
  logic             addr_err_q;

  // Candidate next-PC values. Loaded targets are forced to word alignment;
  // the raw low bits are only used to flag the misalignment.
  logic [WIDTH-1:0] jump_aligned;
  logic [WIDTH-1:0] bnq_aligned;
  logic             jump_misaligned;
  logic             bnq_misaligned;

  assign jump_aligned    = WIDTH'(align_addr(64'(bus.jump_target)));
  assign bnq_aligned     = WIDTH'(align_addr(64'(bus.bnq)));
  assign jump_misaligned = |bus.jump_target[1:0];
  assign bnq_misaligned  = |bus.bnq[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= PC_RUN;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + STEP;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      case (state_q)
        PC_RUN: begin
          if (bus.jump) begin
            // A jump redirects even under stall: decode has already
            // committed to it and the target does not depend on the adder.
            pc_q          <= jump_aligned;
            pc_plus4_q    <= jump_aligned + STEP;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b1;
            addr_err_q    <= jump_misaligned;
            state_q       <= PC_RUN;
          end else if (bus.branch_taken && !bus.stop) begin
            // The adder captures the target on this edge; hold pc and
            // mark the slot invalid until bnq is ready next cycle.
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b1;
            addr_err_q    <= 1'b0;
            state_q       <= PC_BR_WAIT;
          end else if (bus.stop) begin
            // Stall: pc, pc_plus4 and fetch_valid hold. A branch_taken
            // seen here is dropped; decode re-presents it.
            flush_q    <= 1'b0;
            addr_err_q <= 1'b0;
            state_q    <= PC_RUN;
          end else begin
            pc_q          <= pc_plus4_q;
            pc_plus4_q    <= pc_plus4_q + STEP;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
            addr_err_q    <= 1'b0;
            state_q       <= PC_RUN;
          end
        end

        PC_BR_WAIT: begin
          // Unconditional: if stop rises here the adder is already frozen
          // holding the right target, so loading it now is safe. flush
          // drops so a single redirect never flushes twice.
          pc_q          <= bnq_aligned;
          pc_plus4_q    <= bnq_aligned + STEP;
          fetch_valid_q <= 1'b1;
          flush_q       <= 1'b0;
          addr_err_q    <= bnq_misaligned;
          state_q       <= PC_RUN;
        end

        default: begin
          state_q       <= PC_RUN;
          pc_q          <= RESET_PC;
          pc_plus4_q    <= RESET_PC + STEP;
          fetch_valid_q <= 1'b0;
          flush_q       <= 1'b0;
          addr_err_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
  assign bus.addr_err    = addr_err_q;
  assign state           = state_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed testbench for pc_sequencer: linear sequence of steps with
//   hand-computed expected values, each compared by an immediate assertion.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
  import fetch_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic      clk = 1'b0;
  logic      rst = 1'b0;
  pc_state_t state;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(W)) bus ();

  pc_sequencer #(
    .WIDTH   (W),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .state(state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Check the full output set in one call.
  task automatic check_all(input string tag, input logic [W-1:0] e_pc,
                           input logic [W-1:0] e_p4, input logic e_fv,
                           input logic e_fl, input logic e_ae,
                           input pc_state_t e_st);
    check({tag, ".pc"},          bus.pc,                e_pc);
    check({tag, ".pc_plus4"},    bus.pc_plus4,          e_p4);
    check({tag, ".fetch_valid"}, W'(bus.fetch_valid),   W'(e_fv));
    check({tag, ".flush"},       W'(bus.flush),         W'(e_fl));
    check({tag, ".addr_err"},    W'(bus.addr_err),      W'(e_ae));
    check({tag, ".state"},       W'(state),             W'(e_st));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic s, input logic bt, input logic [W-1:0] bq,
                       input logic j, input logic [W-1:0] jt);
    bus.stop         = s;
    bus.branch_taken = bt;
    bus.bnq          = bq;
    bus.jump         = j;
    bus.jump_target  = jt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    #12;
    // Reset state
    check_all("reset", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, PC_RUN);

    // 1. Release and run sequentially
    @(negedge clk);
    rst = 1'b1;
    step(); check_all("seq1", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, PC_RUN);
    step(); check_all("seq2", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0, PC_RUN);

    // 2. Stall three cycles at pc=8
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    step(); check_all("stall1", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0, PC_RUN);
    step(); check_all("stall2", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0, PC_RUN);
    step(); check_all("stall3", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0, PC_RUN);
    idle();
    step(); check_all("unstall", 32'hC, 32'h10, 1'b1, 1'b0, 1'b0, PC_RUN);
    step(); check_all("seq10", 32'h10, 32'h14, 1'b1, 1'b0, 1'b0, PC_RUN);

    // 3. Taken branch from pc=0x10; wait cycle ignores stop/jump
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    step(); check_all("br_take", 32'h10, 32'h14, 1'b0, 1'b1, 1'b0, PC_BR_WAIT);
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'h999);
    step(); check_all("br_load", 32'h40, 32'h44, 1'b1, 1'b0, 1'b0, PC_RUN);

    // 4. Jump beats branch
    drive(1'b0, 1'b1, 32'h80, 1'b1, 32'h200);
    step(); check_all("jmp_br", 32'h200, 32'h204, 1'b1, 1'b1, 1'b0, PC_RUN);
    idle();
    step(); check_all("jmp_after", 32'h204, 32'h208, 1'b1, 1'b0, 1'b0, PC_RUN);
    // Jump under stall
    drive(1'b1, 1'b1, 32'h80, 1'b1, 32'h300);
    step(); check_all("jmp_stop", 32'h300, 32'h304, 1'b1, 1'b1, 1'b0, PC_RUN);
    // Branch under stall is dropped
    drive(1'b1, 1'b1, 32'h80, 1'b0, '0);
    step(); check_all("br_stop", 32'h300, 32'h304, 1'b1, 1'b0, 1'b0, PC_RUN);
    idle();
    step(); check_all("br_dropped", 32'h304, 32'h308, 1'b1, 1'b0, 1'b0, PC_RUN);

    // 5. Misaligned jump target
    drive(1'b0, 1'b0, '0, 1'b1, 32'h103);
    step(); check_all("mis_jmp", 32'h100, 32'h104, 1'b1, 1'b1, 1'b1, PC_RUN);
    idle();
    step(); check_all("mis_clr", 32'h104, 32'h108, 1'b1, 1'b0, 1'b0, PC_RUN);

    // Wrap at top of address space
    drive(1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
    step(); check_all("wrap_top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 1'b0, PC_RUN);
    idle();
    step(); check_all("wrap0", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, PC_RUN);
    step(); check_all("wrap4", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, PC_RUN);

    // Misaligned branch target
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    step(); check_all("mis_br_take", 32'h4, 32'h8, 1'b0, 1'b1, 1'b0, PC_BR_WAIT);
    drive(1'b0, 1'b0, 32'h82, 1'b0, '0);
    step(); check_all("mis_br_load", 32'h80, 32'h84, 1'b1, 1'b0, 1'b1, PC_RUN);
    idle();
    step(); check_all("mis_br_clr", 32'h84, 32'h88, 1'b1, 1'b0, 1'b0, PC_RUN);

    // 6. Reset while in PC_BR_WAIT
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    step(); check_all("rst_br_take", 32'h84, 32'h88, 1'b0, 1'b1, 1'b0, PC_BR_WAIT);
    drive(1'b0, 1'b0, 32'h500, 1'b0, '0);
    #2;
    rst = 1'b0;
    #1;
    check_all("rst_mid", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, PC_RUN);
    @(negedge clk);
    rst = 1'b1;
    step(); check_all("rst_after", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, PC_RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_sequencer
